inst_mem_loader: RTL and testbench

Write-side counterpart of the byte-addressable instruction memory. Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them little-endian, one byte per cycle, through a byte write port starting at BASE_ADDR. Sits between the boot/debug channel and the instruction memory. Holds `busy` high so the core can be kept in reset until the load completes.

---
 rtl/inst_mem_loader.sv | 161 ++++++++++++++++
 tb/tb_inst_mem_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: streams 32-bit instruction words arriving over a valid/ready
// handshake into a byte-wide memory write port, little-endian, starting at
// BASE_ADDR. Holds busy high while a load runs so the core can be kept in reset.
// A word whose last byte would land past MEM_BYTES-1 is refused before any of
// its bytes are written, and the load ends in a sticky error.
// Optional build macro: LOADER_CHECKSUM_EN adds a running 32-bit modular sum
// of all accepted words on the checksum output; without it checksum is zero.
module inst_mem_loader #(
   parameter int unsigned MEM_BYTES = 32,
   parameter int unsigned BASE_ADDR = 4,
   parameter int unsigned CNT_W     = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] num_words,
   input  logic             word_valid,
   input  logic [31:0]      word_data,
   output logic             word_ready,
   output logic             wr_en,
   output logic [31:0]      wr_addr,
   output logic [7:0]       wr_data,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [31:0]      checksum
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_WORD,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [31:0] LP_BASE = 32'(BASE_ADDR);
   localparam logic [31:0] LP_LAST = 32'(MEM_BYTES - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [31:0]      r_addr;
   logic [CNT_W-1:0] r_words_left;
   logic [31:0]      r_word;
   logic [1:0]       r_byte_idx;
   logic             r_error;

   logic             w_overflow;
   logic             w_start_acc;
   logic             w_xfer;
   logic             w_last_byte;

   // A whole word must fit below the end of memory before it is accepted.
   assign w_overflow  = (r_addr + 32'd3) > LP_LAST;
   assign w_last_byte = (r_byte_idx == 2'd3);

   // State register.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // Next-state decode and Moore/handshake outputs.
   always_comb begin
      // NOTE: every output gets a default first, so no branch can infer a latch.
      w_next_state = r_state;
      w_start_acc  = 1'b0;
      w_xfer       = 1'b0;
      word_ready   = 1'b0;
      wr_en        = 1'b0;
      wr_addr      = 32'd0;
      wr_data      = 8'd0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_start_acc  = 1'b1;
               w_next_state = (num_words == '0) ? S_DONE : S_WAIT_WORD;
            end
         end
         S_WAIT_WORD: begin
            busy = 1'b1;
            if (w_overflow) begin
               w_next_state = S_ERR;
            end else begin
               word_ready = 1'b1;
               if (word_valid) begin
                  w_xfer       = 1'b1;
                  w_next_state = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            busy    = 1'b1;
            wr_en   = 1'b1;
            wr_addr = r_addr;
            wr_data = r_word[{r_byte_idx, 3'b000} +: 8];
            if (w_last_byte) begin
               w_next_state = (r_words_left == CNT_W'(1)) ? S_DONE : S_WAIT_WORD;
            end
         end
         S_DONE: begin
            done         = 1'b1;
            w_next_state = S_IDLE;
         end
         S_ERR: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Load datapath: address, word counter, captured word, byte index, sticky error.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_addr       <= 32'd0;
         r_words_left <= '0;
         r_word       <= 32'd0;
         r_byte_idx   <= 2'd0;
         r_error      <= 1'b0;
      end else begin
         if (w_start_acc) begin
            r_addr       <= LP_BASE;
            r_words_left <= num_words;
            r_error      <= 1'b0;
         end
         if (w_xfer) begin
            r_word     <= word_data;
            r_byte_idx <= 2'd0;
         end
         if (r_state == S_WRITE) begin
            r_addr     <= r_addr + 32'd1;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (w_last_byte) r_words_left <= r_words_left - CNT_W'(1);
         end
         if ((r_state == S_WAIT_WORD) && w_overflow) r_error <= 1'b1;
      end
   end

   assign error = r_error;

`ifdef LOADER_CHECKSUM_EN
   logic [31:0] r_checksum;

   // Running modular sum of accepted words; survives DONE/ERR until next start.
   always_ff @(posedge clock) begin
      if (!reset)           r_checksum <= 32'd0;
      else if (w_start_acc) r_checksum <= 32'd0;
      else if (w_xfer)      r_checksum <= r_checksum + word_data;
   end

   assign checksum = r_checksum;
`else
   assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: directed bench for inst_mem_loader with hand-computed
// expectations. A negedge monitor mirrors the byte write port into a small
// memory and counts write strobes and done pulses.
module tb_inst_mem_loader;

   localparam int unsigned MEM_BYTES = 32;
   localparam int unsigned BASE_ADDR = 4;
   localparam int unsigned CNT_W     = 8;

   logic             clock = 1'b0;
   logic             reset;
   logic             start;
   logic [CNT_W-1:0] num_words;
   logic             word_valid;
   logic [31:0]      word_data;
   logic             word_ready;
   logic             wr_en;
   logic [31:0]      wr_addr;
   logic [7:0]       wr_data;
   logic             busy;
   logic             done;
   logic             error;
   logic [31:0]      checksum;

   int n_cmp = 0;
   int n_bad = 0;

   int          wr_count   = 0;
   int          done_count = 0;
   logic [31:0] last_addr  = 32'd0;
   logic [7:0]  last_data  = 8'd0;
   logic [7:0]  tb_mem [0:63];

   logic [31:0] prog [6] = '{32'h00940333, 32'h412983b3, 32'h00f768b3,
                             32'h00d67fb3, 32'h017b4e33, 32'h01bd2f33};
   int          gaps [6] = '{0, 2, 1, 3, 0, 1};

   always #5 clock = ~clock;

   inst_mem_loader #(
      .MEM_BYTES(MEM_BYTES),
      .BASE_ADDR(BASE_ADDR),
      .CNT_W    (CNT_W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .num_words (num_words),
      .word_valid(word_valid),
      .word_data (word_data),
      .word_ready(word_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .checksum  (checksum)
   );

   // Write-port and done monitor, sampled mid-cycle.
   always @(negedge clock) begin
      if (wr_en === 1'b1) begin
         tb_mem[wr_addr[5:0]] = wr_data;
         wr_count++;
         last_addr = wr_addr;
         last_data = wr_data;
      end
      if (done === 1'b1) done_count++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start_load(input logic [CNT_W-1:0] n);
      start     = 1'b1;
      num_words = n;
      tick();
      start     = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d, input int gap);
      int waited;
      word_valid = 1'b0;
      repeat (gap) tick();
      word_valid = 1'b1;
      word_data  = d;
      waited     = 0;
      while (word_ready !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      if (waited >= 50) begin
         check("send_timeout", 32'd0, 32'd1);
         word_valid = 1'b0;
         return;
      end
      tick();
      word_valid = 1'b0;
      word_data  = 32'hDEAD_BEEF;
   endtask

   task automatic wait_done(input string tag);
      int waited;
      waited = 0;
      while (done !== 1'b1 && waited < 100) begin
         tick();
         waited++;
      end
      check(tag, {31'd0, done}, 32'd1);
   endtask

   initial begin
      int          base_wr;
      int          base_done;
      int          waited;
      logic        saw_ready;
      logic [31:0] sum;
      logic [31:0] exp_sum;
      logic [31:0] got_word;
      int          a;

      reset      = 1'b0;
      start      = 1'b0;
      num_words  = '0;
      word_valid = 1'b1;
      word_data  = 32'hFFFF_FFFF;

      // 1: reset held two cycles, word_valid high must not raise word_ready.
      tick();
      tick();
      check("rst_word_ready", {31'd0, word_ready}, 32'd0);
      check("rst_wr_en",      {31'd0, wr_en},      32'd0);
      check("rst_busy",       {31'd0, busy},       32'd0);
      check("rst_done",       {31'd0, done},       32'd0);
      check("rst_error",      {31'd0, error},      32'd0);
      check("rst_wr_addr",    wr_addr,             32'd0);
      check("rst_wr_data",    {24'd0, wr_data},    32'd0);
      check("rst_checksum",   checksum,            32'd0);
      word_valid = 1'b0;
      reset      = 1'b1;
      tick();

      // 2: single word, exact cycle timing of the four byte writes and done.
      base_wr = wr_count;
      start_load(8'd1);
      check("t2_busy_after_start", {31'd0, busy},       32'd1);
      check("t2_ready",            {31'd0, word_ready}, 32'd1);
      word_valid = 1'b1;
      word_data  = 32'h00940333;
      tick();
      word_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("t2_wr_en",   {31'd0, wr_en},   32'd1);
         check("t2_wr_addr", wr_addr,          32'd4 + 32'(i));
         check("t2_wr_data", {24'd0, wr_data}, (i == 0) ? 32'h33 : (i == 1) ? 32'h03 :
                                               (i == 2) ? 32'h94 : 32'h00);
         tick();
      end
      check("t2_done",      {31'd0, done}, 32'd1);
      check("t2_busy_fall", {31'd0, busy}, 32'd0);
      check("t2_wr_en_off", {31'd0, wr_en}, 32'd0);
      tick();
      check("t2_done_one_cycle", {31'd0, done}, 32'd0);
      check("t2_writes", 32'(wr_count - base_wr), 32'd4);
`ifdef LOADER_CHECKSUM_EN
      check("t2_checksum", checksum, 32'h00940333);
`else
      check("t2_checksum", checksum, 32'd0);
`endif

      // 3: six words with valid gaps.
      base_wr = wr_count;
      start_load(8'd6);
      for (int i = 0; i < 6; i++) send_word(prog[i], gaps[i]);
      wait_done("t3_done");
      check("t3_last_addr", last_addr, 32'd27);
      check("t3_last_data", {24'd0, last_data}, 32'h01);
      tick();
      check("t3_writes", 32'(wr_count - base_wr), 32'd24);
      for (int i = 0; i < 6; i++) begin
         a = 4 + 4 * i;
         got_word = {tb_mem[a + 3], tb_mem[a + 2], tb_mem[a + 1], tb_mem[a]};
         check($sformatf("t3_mem_word%0d", i), got_word, prog[i]);
      end
      sum = 32'd0;
      for (int i = 0; i < 6; i++) sum = sum + prog[i];
`ifdef LOADER_CHECKSUM_EN
      exp_sum = sum;
`else
      exp_sum = 32'd0;
`endif
      check("t3_checksum", checksum, exp_sum);

      // 4: eight words overflow a 32-byte memory after seven.
      base_wr   = wr_count;
      base_done = done_count;
      start_load(8'd8);
      for (int i = 0; i < 7; i++) send_word(prog[i % 6] ^ 32'h5A5A_0000, 0);
      word_valid = 1'b1;
      word_data  = 32'h1234_5678;
      saw_ready  = 1'b0;
      waited     = 0;
      while (error !== 1'b1 && waited < 20) begin
         if (word_ready === 1'b1) saw_ready = 1'b1;
         tick();
         waited++;
      end
      word_valid = 1'b0;
      check("t4_error_set",   {31'd0, error},     32'd1);
      check("t4_err_busy",    {31'd0, busy},      32'd0);
      check("t4_err_wr_en",   {31'd0, wr_en},     32'd0);
      check("t4_no_ready_8",  {31'd0, saw_ready}, 32'd0);
      check("t4_writes",      32'(wr_count - base_wr), 32'd28);
      check("t4_last_addr",   last_addr, 32'd31);
      tick();
      check("t4_error_held",  {31'd0, error}, 32'd1);
      check("t4_no_done",     32'(done_count - base_done), 32'd0);

      // 5: zero-word load clears error and completes at once.
      base_wr = wr_count;
      start_load(8'd0);
      check("t5_error_cleared", {31'd0, error},      32'd0);
      check("t5_done",          {31'd0, done},       32'd1);
      check("t5_no_wr_en",      {31'd0, wr_en},      32'd0);
      check("t5_no_ready",      {31'd0, word_ready}, 32'd0);
      check("t5_checksum_clr",  checksum,            32'd0);
      tick();
      check("t5_done_off", {31'd0, done}, 32'd0);
      check("t5_writes",   32'(wr_count - base_wr), 32'd0);

      // 6a: reset during the third byte write aborts the load.
      start_load(8'd2);
      check("t6_busy", {31'd0, busy}, 32'd1);
      send_word(32'hA1B2C3D4, 0);
      tick();
      tick();
      check("t6_byte2_addr", wr_addr,          32'd6);
      check("t6_byte2_data", {24'd0, wr_data}, 32'hB2);
      reset = 1'b0;
      tick();
      check("t6_rst_wr_en", {31'd0, wr_en},      32'd0);
      check("t6_rst_busy",  {31'd0, busy},       32'd0);
      check("t6_rst_ready", {31'd0, word_ready}, 32'd0);
      check("t6_rst_addr",  wr_addr,             32'd0);
      reset = 1'b1;
      tick();

      // 6b: start pulses while busy must not change the word count.
      base_wr   = wr_count;
      base_done = done_count;
      start_load(8'd1);
      start     = 1'b1;
      num_words = 8'd5;
      tick();
      start     = 1'b0;
      send_word(32'h0BAD_F00D, 0);
      start     = 1'b1;
      num_words = 8'd5;
      tick();
      start     = 1'b0;
      wait_done("t6_done");
      tick();
      check("t6_ignored_writes", 32'(wr_count - base_wr), 32'd4);
      check("t6_ignored_done",   32'(done_count - base_done), 32'd1);
      check("t6_idle_busy",      {31'd0, busy}, 32'd0);
      got_word = {tb_mem[7], tb_mem[6], tb_mem[5], tb_mem[4]};
      check("t6_mem_word", got_word, 32'h0BAD_F00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
